pc_fetch_sequencer: RTL and testbench

Multi-cycle fetch/commit sequencer that owns the architectural PC for the LEGv8 datapath.
- Issues instruction-memory requests with a req/ack handshake and holds the fetched instruction for the datapath.
- On datapath commit, computes and loads the next PC from the branch controls: PC+imm or PC+4.
- Sits between instruction memory and the datapath control/ALU; replaces the free-running PC register of the single-cycle core.

---
 rtl/pc_fetch_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//   Multi-cycle fetch/commit sequencer owning the architectural PC of the
//   LEGv8 datapath. It fetches one instruction over a req/ack handshake,
//   holds it for the datapath until Commit, then loads the next PC
//   (PC+imm for a taken branch, PC+4 otherwise) and refetches.
//
// Parameters
//   TIMEOUT  FETCH cycles without ImemAck before entering FAULT (1..255)
//   INSTR_W  instruction word width
//
// Optional build macro
//   PC_ALIGN_CHECK_EN  when defined, a misaligned next PC (bits [1:0] != 0)
//                      at Commit, or a misaligned StartPC out of reset,
//                      raises Fault instead of being loaded.
//
// Ports
//   CLK, Reset_L              clock (rising edge), synchronous active-low reset
//   StartPC                   PC loaded while in reset
//   Run                       1 = keep fetching, 0 = stop after current instr
//   ImemReq/ImemAddr          fetch request and address (held until ack)
//   ImemAck/ImemData          memory response
//   Instr/InstrValid          latched instruction awaiting Commit
//   Commit                    datapath done; branch controls valid this cycle
//   Branch/Uncondbranch       conditional (CBZ) / unconditional (B) branch
//   ALUZero, SignExtImm64     zero flag and pre-shifted byte offset
//   CurrentPC, InstrCount     architectural PC and retired-instruction count
//   Fault                     sticky fault flag
module pc_fetch_sequencer #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned INSTR_W = 32
) (
    input  logic               CLK,
    input  logic               Reset_L,
    input  logic [63:0]        StartPC,
    input  logic               Run,
    output logic               ImemReq,
    output logic [63:0]        ImemAddr,
    input  logic               ImemAck,
    input  logic [INSTR_W-1:0] ImemData,
    output logic [INSTR_W-1:0] Instr,
    output logic               InstrValid,
    input  logic               Commit,
    input  logic               Branch,
    input  logic               Uncondbranch,
    input  logic               ALUZero,
    input  logic [63:0]        SignExtImm64,
    output logic [63:0]        CurrentPC,
    output logic [31:0]        InstrCount,
    output logic               Fault
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        FAULT
    } seqState;

    // The counter value seen on the edge that would be the TIMEOUT-th
    // FETCH cycle without an ack.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    seqState              state;
    seqState              stateNext;
    logic [7:0]           timeoutCnt;
    logic                 timeoutHit;
    logic                 takeBranch;
    logic [63:0]          commitPc;
    logic                 commitBad;
    logic                 startBad;

    logic                 imemReqNext;
    logic [63:0]          imemAddrNext;
    logic [INSTR_W-1:0]   instrNext;
    logic                 instrValidNext;
    logic [63:0]          currentPcNext;
    logic [31:0]          instrCountNext;
    logic                 faultNext;
    logic [7:0]           timeoutCntNext;

    assign timeoutHit = (timeoutCnt == TIMEOUT_LAST);
    assign takeBranch = Uncondbranch | (Branch & ALUZero);
    assign commitPc   = takeBranch ? (CurrentPC + SignExtImm64) : (CurrentPC + 64'd4);

`ifdef PC_ALIGN_CHECK_EN
    assign commitBad = |commitPc[1:0];
    // CurrentPC can only be misaligned in IDLE if StartPC was, since a
    // misaligned commit never loads the PC.
    assign startBad  = |CurrentPC[1:0];
`else
    assign commitBad = 1'b0;
    assign startBad  = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (startBad) begin
                    stateNext = FAULT;
                end else if (Run) begin
                    stateNext = FETCH;
                end
            end
            FETCH: begin
                // An ack on the timeout edge still completes the fetch.
                if (ImemAck) begin
                    stateNext = EXEC;
                end else if (timeoutHit) begin
                    stateNext = FAULT;
                end
            end
            EXEC: begin
                if (Commit) begin
                    if (commitBad) begin
                        stateNext = FAULT;
                    end else if (Run) begin
                        stateNext = FETCH;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            FAULT:   stateNext = FAULT;
            default: stateNext = IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs
    always_comb begin
        imemReqNext    = ImemReq;
        imemAddrNext   = ImemAddr;
        instrNext      = Instr;
        instrValidNext = InstrValid;
        currentPcNext  = CurrentPC;
        instrCountNext = InstrCount;
        faultNext      = Fault;
        timeoutCntNext = timeoutCnt;
        case (state)
            IDLE: begin
                imemReqNext    = 1'b0;
                instrValidNext = 1'b0;
                timeoutCntNext = '0;
                if (startBad) begin
                    faultNext = 1'b1;
                end else if (Run) begin
                    imemReqNext  = 1'b1;
                    imemAddrNext = CurrentPC;
                end
            end
            FETCH: begin
                if (ImemAck) begin
                    instrNext      = ImemData;
                    instrValidNext = 1'b1;
                    imemReqNext    = 1'b0;
                    timeoutCntNext = '0;
                end else if (timeoutHit) begin
                    imemReqNext    = 1'b0;
                    faultNext      = 1'b1;
                    timeoutCntNext = '0;
                end else begin
                    timeoutCntNext = timeoutCnt + 8'd1;
                end
            end
            EXEC: begin
                if (Commit) begin
                    instrValidNext = 1'b0;
                    if (commitBad) begin
                        faultNext = 1'b1;
                    end else begin
                        // Zero-bubble refetch: request goes out on the
                        // same edge that loads the new PC.
                        currentPcNext  = commitPc;
                        imemAddrNext   = commitPc;
                        instrCountNext = InstrCount + 32'd1;
                        imemReqNext    = Run;
                        timeoutCntNext = '0;
                    end
                end
            end
            FAULT: begin
                imemReqNext    = 1'b0;
                instrValidNext = 1'b0;
                faultNext      = 1'b1;
            end
            default: begin
                imemReqNext    = 1'b0;
                instrValidNext = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            ImemReq    <= 1'b0;
            ImemAddr   <= StartPC;
            Instr      <= '0;
            InstrValid <= 1'b0;
            CurrentPC  <= StartPC;
            InstrCount <= '0;
            Fault      <= 1'b0;
            timeoutCnt <= '0;
        end else begin
            ImemReq    <= imemReqNext;
            ImemAddr   <= imemAddrNext;
            Instr      <= instrNext;
            InstrValid <= instrValidNext;
            CurrentPC  <= currentPcNext;
            InstrCount <= instrCountNext;
            Fault      <= faultNext;
            timeoutCnt <= timeoutCntNext;
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        resetL;
    logic [63:0] startPc;
    logic        run;
    logic        imemReq;
    logic [63:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic [31:0] instr;
    logic        instrValid;
    logic        commit;
    logic        branch;
    logic        uncond;
    logic        aluZero;
    logic [63:0] imm;
    logic [63:0] currentPc;
    logic [31:0] instrCount;
    logic        fault;

    int unsigned passCnt = 0;
    int unsigned totalCnt = 0;

    logic [63:0] expAddrQ[$];
    logic [31:0] expInstrQ[$];
    logic [63:0] expA;
    logic [31:0] expI;

    pc_fetch_sequencer #(.TIMEOUT(4), .INSTR_W(32)) dut (
        .CLK(clk), .Reset_L(resetL), .StartPC(startPc), .Run(run),
        .ImemReq(imemReq), .ImemAddr(imemAddr), .ImemAck(imemAck), .ImemData(imemData),
        .Instr(instr), .InstrValid(instrValid), .Commit(commit), .Branch(branch),
        .Uncondbranch(uncond), .ALUZero(aluZero), .SignExtImm64(imm),
        .CurrentPC(currentPc), .InstrCount(instrCount), .Fault(fault)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] refNextPc(input logic [63:0] pc, input logic u,
                                              input logic b, input logic z,
                                              input logic [63:0] off);
        if (u || (b && z)) return pc + off;
        return pc + 64'd4;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearCtl();
        commit = 0; branch = 0; uncond = 0; aluZero = 0; imm = '0; imemAck = 0;
    endtask

    // Reset with the given StartPC and leave the DUT in FETCH at that PC.
    task automatic startAt(input logic [63:0] pc);
        clearCtl();
        resetL = 0; startPc = pc; run = 1;
        tick();
        resetL = 1;
        tick();
    endtask

    task automatic test_reset();
        clearCtl();
        resetL = 0; startPc = 64'h100; run = 0; imemData = '0;
        tick(); tick();
        if (currentPc !== 64'h100) $display("FAIL reset_pc: got %h want %h", currentPc, 64'h100); else passCnt++; totalCnt++;
        if (fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", fault); else passCnt++; totalCnt++;
        if (instrCount !== 32'd0) $display("FAIL reset_count: got %0d want 0", instrCount); else passCnt++; totalCnt++;
        if (imemReq !== 1'b0) $display("FAIL reset_req: got %b want 0", imemReq); else passCnt++; totalCnt++;
        if (imemAddr !== 64'h100) $display("FAIL reset_addr: got %h want %h", imemAddr, 64'h100); else passCnt++; totalCnt++;
        if ({instrValid, instr} !== 33'd0) $display("FAIL reset_instr: got %b/%h want 0/0", instrValid, instr); else passCnt++; totalCnt++;
        resetL = 1;
        tick();
        if (imemReq !== 1'b0) $display("FAIL idle_no_run: got %b want 0", imemReq); else passCnt++; totalCnt++;
        expAddrQ.push_back(64'h100);
        run = 1;
        tick();
        expA = expAddrQ.pop_front();
        if (imemReq !== 1'b1) $display("FAIL run_req: got %b want 1", imemReq); else passCnt++; totalCnt++;
        if (imemAddr !== expA) $display("FAIL run_addr: got %h want %h", imemAddr, expA); else passCnt++; totalCnt++;
    endtask

    task automatic test_fetch_commit();
        tick(); tick();
        if (imemReq !== 1'b1) $display("FAIL req_held: got %b want 1", imemReq); else passCnt++; totalCnt++;
        expInstrQ.push_back(32'h8B020020);
        imemAck = 1; imemData = 32'h8B020020;
        tick();
        imemAck = 0; imemData = 32'hDEADBEEF;
        expI = expInstrQ.pop_front();
        if (instr !== expI) $display("FAIL fetch_instr: got %h want %h", instr, expI); else passCnt++; totalCnt++;
        if (instrValid !== 1'b1) $display("FAIL fetch_valid: got %b want 1", instrValid); else passCnt++; totalCnt++;
        if (imemReq !== 1'b0) $display("FAIL fetch_req_drop: got %b want 0", imemReq); else passCnt++; totalCnt++;
        tick();
        if ({instrValid, currentPc} !== {1'b1, 64'h100}) $display("FAIL exec_stall: got %b/%h want 1/100", instrValid, currentPc); else passCnt++; totalCnt++;
        imemAck = 1;
        tick();
        imemAck = 0;
        if (instr !== 32'h8B020020) $display("FAIL ack_in_exec: got %h want 8b020020", instr); else passCnt++; totalCnt++;
        commit = 1;
        expAddrQ.push_back(refNextPc(64'h100, 0, 0, 0, 64'h0));
        tick();
        commit = 0;
        expA = expAddrQ.pop_front();
        if (imemReq !== 1'b1) $display("FAIL zero_bubble_req: got %b want 1", imemReq); else passCnt++; totalCnt++;
        if (imemAddr !== expA) $display("FAIL seq_addr: got %h want %h", imemAddr, expA); else passCnt++; totalCnt++;
        if (currentPc !== 64'h104) $display("FAIL seq_pc: got %h want 104", currentPc); else passCnt++; totalCnt++;
        if (instrCount !== 32'd1) $display("FAIL seq_count: got %0d want 1", instrCount); else passCnt++; totalCnt++;
        if (instrValid !== 1'b0) $display("FAIL commit_valid_drop: got %b want 0", instrValid); else passCnt++; totalCnt++;
    endtask

    task automatic test_branch();
        imemAck = 1; imemData = 32'hB4000040;
        tick();
        imemAck = 0;
        commit = 1; branch = 1; aluZero = 1; imm = 64'h40;
        expAddrQ.push_back(refNextPc(64'h104, 0, 1, 1, 64'h40));
        tick();
        clearCtl();
        expA = expAddrQ.pop_front();
        if (currentPc !== 64'h144) $display("FAIL cbz_taken_pc: got %h want 144", currentPc); else passCnt++; totalCnt++;
        if (imemAddr !== expA) $display("FAIL cbz_taken_addr: got %h want %h", imemAddr, expA); else passCnt++; totalCnt++;
        if (instrCount !== 32'd2) $display("FAIL cbz_taken_count: got %0d want 2", instrCount); else passCnt++; totalCnt++;
        startAt(64'h104);
        imemAck = 1;
        tick();
        imemAck = 0;
        commit = 1; branch = 1; aluZero = 0; imm = 64'h40;
        expAddrQ.push_back(refNextPc(64'h104, 0, 1, 0, 64'h40));
        tick();
        clearCtl();
        expA = expAddrQ.pop_front();
        if (currentPc !== 64'h108) $display("FAIL cbz_not_taken_pc: got %h want 108", currentPc); else passCnt++; totalCnt++;
        if (imemAddr !== expA) $display("FAIL cbz_not_taken_addr: got %h want %h", imemAddr, expA); else passCnt++; totalCnt++;
    endtask

    task automatic test_uncond_wrap();
        startAt(64'h0);
        imemAck = 1;
        tick();
        imemAck = 0;
        commit = 1; uncond = 1; branch = 1; aluZero = 0; imm = 64'hFFFF_FFFF_FFFF_FFF8;
        expAddrQ.push_back(64'hFFFF_FFFF_FFFF_FFF8);
        tick();
        clearCtl();
        expA = expAddrQ.pop_front();
        if (currentPc !== 64'hFFFF_FFFF_FFFF_FFF8) $display("FAIL b_wrap_pc: got %h want fffffffffffffff8", currentPc); else passCnt++; totalCnt++;
        if (imemAddr !== expA) $display("FAIL b_wrap_addr: got %h want %h", imemAddr, expA); else passCnt++; totalCnt++;
        startAt(64'h0);
        imemAck = 1;
        tick();
        imemAck = 0;
        commit = 1; uncond = 1; imm = 64'h2;
        tick();
        clearCtl();
`ifdef PC_ALIGN_CHECK_EN
        if (fault !== 1'b1) $display("FAIL align_fault: got %b want 1", fault); else passCnt++; totalCnt++;
        if (currentPc !== 64'h0) $display("FAIL align_pc_hold: got %h want 0", currentPc); else passCnt++; totalCnt++;
        if ({imemReq, instrCount} !== 33'd0) $display("FAIL align_req_count: got %b/%0d want 0/0", imemReq, instrCount); else passCnt++; totalCnt++;
        clearCtl();
        resetL = 0; startPc = 64'h102; run = 0;
        tick();
        resetL = 1;
        tick();
        if (fault !== 1'b1) $display("FAIL align_start_fault: got %b want 1", fault); else passCnt++; totalCnt++;
`else
        if (fault !== 1'b0) $display("FAIL unaligned_no_fault: got %b want 0", fault); else passCnt++; totalCnt++;
        if (currentPc !== 64'h2) $display("FAIL unaligned_pc: got %h want 2", currentPc); else passCnt++; totalCnt++;
        if (imemAddr !== 64'h2) $display("FAIL unaligned_addr: got %h want 2", imemAddr); else passCnt++; totalCnt++;
`endif
    endtask

    task automatic test_run_stop();
        startAt(64'h400);
        imemAck = 1;
        tick();
        imemAck = 0;
        run = 0; commit = 1;
        tick();
        commit = 0;
        if ({imemReq, instrValid} !== 2'b00) $display("FAIL stop_handshake: got %b/%b want 0/0", imemReq, instrValid); else passCnt++; totalCnt++;
        if (currentPc !== 64'h404) $display("FAIL stop_pc: got %h want 404", currentPc); else passCnt++; totalCnt++;
        tick(); tick();
        if (imemReq !== 1'b0) $display("FAIL idle_stays: got %b want 0", imemReq); else passCnt++; totalCnt++;
        expAddrQ.push_back(64'h404);
        run = 1;
        tick();
        expA = expAddrQ.pop_front();
        if ({imemReq, imemAddr} !== {1'b1, expA}) $display("FAIL restart: got %b/%h want 1/%h", imemReq, imemAddr, expA); else passCnt++; totalCnt++;
    endtask

    task automatic test_timeout();
        startAt(64'h200);
        for (int i = 0; i < 3; i++) tick();
        if ({imemReq, fault} !== 2'b10) $display("FAIL pre_timeout: got %b/%b want 1/0", imemReq, fault); else passCnt++; totalCnt++;
        tick();
        if (fault !== 1'b1) $display("FAIL timeout_fault: got %b want 1", fault); else passCnt++; totalCnt++;
        if (imemReq !== 1'b0) $display("FAIL timeout_req: got %b want 0", imemReq); else passCnt++; totalCnt++;
        imemAck = 1; commit = 1;
        tick(); tick();
        clearCtl();
        if ({fault, imemReq, instrValid} !== 3'b100) $display("FAIL fault_sticky: got %b%b%b want 100", fault, imemReq, instrValid); else passCnt++; totalCnt++;
        if ({currentPc, instrCount} !== {64'h200, 32'd0}) $display("FAIL fault_hold: got %h/%0d want 200/0", currentPc, instrCount); else passCnt++; totalCnt++;
    endtask

    task automatic test_ack_on_timeout();
        startAt(64'h200);
        for (int i = 0; i < 3; i++) tick();
        expInstrQ.push_back(32'h12345678);
        imemAck = 1; imemData = 32'h12345678;
        tick();
        imemAck = 0;
        expI = expInstrQ.pop_front();
        if ({instrValid, fault} !== 2'b10) $display("FAIL ack_wins: got %b/%b want 1/0", instrValid, fault); else passCnt++; totalCnt++;
        if (instr !== expI) $display("FAIL ack_wins_instr: got %h want %h", instr, expI); else passCnt++; totalCnt++;
    endtask

    task automatic test_reset_midflight();
        startAt(64'h300);
        if (imemReq !== 1'b1) $display("FAIL midfetch_pre: got %b want 1", imemReq); else passCnt++; totalCnt++;
        resetL = 0; startPc = 64'h100;
        tick();
        if ({imemReq, currentPc, imemAddr} !== {1'b0, 64'h100, 64'h100}) $display("FAIL midfetch_reset: got %b/%h/%h want 0/100/100", imemReq, currentPc, imemAddr); else passCnt++; totalCnt++;
        resetL = 1; run = 0; imemAck = 1; imemData = 32'hCAFEF00D;
        tick(); tick();
        imemAck = 0;
        if ({imemReq, instrValid, instr} !== 34'd0) $display("FAIL late_ack: got %b/%b/%h want 0/0/0", imemReq, instrValid, instr); else passCnt++; totalCnt++;
        startAt(64'h300);
        imemAck = 1;
        tick();
        imemAck = 0;
        resetL = 0; startPc = 64'h100; commit = 1;
        tick();
        commit = 0; resetL = 1; run = 0;
        if ({instrValid, currentPc, instrCount} !== {1'b0, 64'h100, 32'd0}) $display("FAIL midexec_reset: got %b/%h/%0d want 0/100/0", instrValid, currentPc, instrCount); else passCnt++; totalCnt++;
    endtask

    initial begin
        test_reset();
        test_fetch_commit();
        test_branch();
        test_uncond_wrap();
        test_run_stop();
        test_timeout();
        test_ack_on_timeout();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
